// File: rtl/maxfinder_pkg.sv
// Shared widths, timeout default and FSM state encoding for the maxfinder driver.
package maxfinder_pkg;
    localparam int MF_DW      = 5;
    localparam int MF_TIMEOUT = 64;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;
endpackage

// File: rtl/mf_timeout_ctr.sv
// Purpose: WAIT-cycle counter; tc flags the cycle whose increment would reach TERM.
// Latency: tc is combinational from the current count and en.
// Backpressure: none; holds its count when en is low.
module mf_timeout_ctr
    import maxfinder_pkg::*;
#(
    parameter int TERM = MF_TIMEOUT - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == CNT_W'(TERM - 1));
endmodule

// File: rtl/maxfinder_driver.sv
// Purpose: registers one operand set, pulses the maxfinder, returns its result or a timeout.
// Latency: mf_start 1 cycle after acceptance; out_valid 1 cycle after mf_done or terminal count.
// Backpressure: result held in OUT until out_ready; no new set accepted until IDLE.
module maxfinder_driver
    import maxfinder_pkg::*;
#(
    parameter int TIMEOUT = MF_TIMEOUT,
    parameter int DW      = MF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x1,
    input  logic [DW-1:0] in_x2,
    input  logic [DW-1:0] in_x3,
    input  logic [DW-1:0] in_x4,
    input  logic [DW-1:0] in_eps,
    output logic          mf_start,
    output logic [DW-1:0] mf_x1,
    output logic [DW-1:0] mf_x2,
    output logic [DW-1:0] mf_x3,
    output logic [DW-1:0] mf_x4,
    output logic [DW-1:0] mf_eps,
    input  logic          mf_done,
    input  logic [DW-1:0] mf_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_timeout,
    output logic          busy
);
    state_t state, state_nxt;
    logic   tc;

    mf_timeout_ctr #(.TERM(TIMEOUT - 1)) u_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state == S_START),
        .en  (state == S_WAIT),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (mf_done || tc) state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // in_ready is gated by rst so it stays low for the whole reset window.
    always_comb begin
        in_ready  = rst && (state == S_IDLE);
        mf_start  = (state == S_START);
        out_valid = (state == S_OUT);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mf_x1       <= '0;
            mf_x2       <= '0;
            mf_x3       <= '0;
            mf_x4       <= '0;
            mf_eps      <= '0;
            out_result  <= '0;
            out_timeout <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                mf_x1  <= in_x1;
                mf_x2  <= in_x2;
                mf_x3  <= in_x3;
                mf_x4  <= in_x4;
                mf_eps <= in_eps;
            end
            // A completion on the terminal-count cycle still counts as a real result.
            if (state == S_WAIT) begin
                if (mf_done) begin
                    out_result  <= mf_result;
                    out_timeout <= 1'b0;
                end else if (tc) begin
                    out_result  <= '0;
                    out_timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/maxfinder_driver.md
MAXFINDER_DRIVER -- requirements
Module: maxfinder_driver

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles in WAIT before abort; legal range 2..255.
REQ-002 Parameter DW, default 5: operand width, signed two's complement, 3 fractional bits (00110 = 0.75, 11110 = -0.25).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operand set offered.
REQ-006 in_ready  out  1  driver accepts operand set.
REQ-007 in_x1, in_x2, in_x3, in_x4  in  DW each  candidate values.
REQ-008 in_eps  in  DW  inhibition weight for the maxfinder.
REQ-009 mf_start  out  1  one-cycle start pulse to the maxfinder.
REQ-010 mf_x1, mf_x2, mf_x3, mf_x4, mf_eps  out  DW each  registered operands to the maxfinder.
REQ-011 mf_done  in  1  maxfinder completion.
REQ-012 mf_result  in  DW  maxfinder result, valid with mf_done.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_result  out  DW  captured result.
REQ-016 out_timeout  out  1  result produced by timeout, not by mf_done.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, START, WAIT, OUT.
REQ-019 IDLE: in_ready=1; on in_valid, capture in_x1..x4 and in_eps into mf_* registers and go to START.
REQ-020 in_ready SHALL be 0 in START, WAIT and OUT; no input is accepted while busy.
REQ-021 START: mf_start=1 for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-022 mf_x*/mf_eps SHALL hold stable from START through OUT exit.
REQ-023 mf_done SHALL be ignored in IDLE, START and OUT; sampled only in WAIT.
REQ-024 WAIT: on mf_done, capture mf_result into out_result, set out_timeout=0, go to OUT.
REQ-025 WAIT without mf_done: increment the counter; when it reaches TIMEOUT-1, set out_result=0 and out_timeout=1, then go to OUT.
REQ-026 mf_done in the same cycle the counter reaches TIMEOUT-1: done wins, out_timeout=0.
REQ-027 OUT: out_valid=1 and out_result/out_timeout held until out_ready=1; return to IDLE on that edge.
REQ-028 No bypass: in_ready SHALL not assert in the OUT exit cycle.
REQ-029 Latency: start pulse 1 cycle after acceptance; out_valid 1 cycle after the mf_done edge.
REQ-030 Throughput: one operand set per transaction; minimum 4 cycles between acceptances.

Reset
REQ-031 rst low SHALL force IDLE immediately, regardless of clock.
REQ-032 While rst is low, clear mf_* registers, out_result, out_timeout and the counter to 0; in_ready=0, mf_start=0, out_valid=0, busy=0.
REQ-033 Reset during WAIT or OUT SHALL discard the transaction; a later mf_done SHALL be ignored.

Structure
REQ-034 Package maxfinder_pkg SHALL hold DW, the TIMEOUT default and the state encoding.
REQ-035 Timeout counter SHALL be sub-module mf_timeout_ctr (clear, enable, terminal-count output).

Verification
REQ-036 x1=00110, x2=01000, x3=00100, x4=00010, eps=11110 -> mf_start pulses once, operands appear on mf_*; model done after 20 cycles with 01000 -> out_valid, out_result=01000, out_timeout=0.
REQ-037 Hold out_ready=0 for 10 cycles -> out_valid and out_result stable; in_ready=0 throughout.
REQ-038 TIMEOUT=8, mf_done never asserted -> out_valid 8 cycles after START, out_result=00000, out_timeout=1.
REQ-039 mf_done on the terminal-count cycle -> out_timeout=0, result captured.
REQ-040 rst low mid-WAIT, then mf_done pulse -> all outputs 0, FSM IDLE, no out_valid.
REQ-041 Back-to-back in_valid held high with out_ready=1 -> second set accepted only after IDLE is re-entered, one start per set.
